// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and width helpers for the mult_acc slice
//
// Purpose: FSM state encoding, counter-width helper and default widths used by
//          mult_acc and mult_step.
// Ports:   none (package).

package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2
  } state_t;

  localparam int DEF_BW_MCAND = 8;
  localparam int DEF_BW_MLIER = 8;
  localparam int DEF_BW_PROD  = DEF_BW_MCAND + DEF_BW_MLIER;
  localparam int DEF_BW_ACC   = 20;

  // Bits needed to hold a down-counter that starts at n and stops at 0.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mult_step.sv
// rtl/mult_step.sv - one combinational shift-add iteration of the multiplier
//
// Purpose: adds (or, on the final step of a signed multiplier, subtracts) the
//          multiplicand to the current partial high word. The caller shifts
//          {carry, sum_hi} right by one to form the next partial word.
// Ports:
//   hi               in  BW_MCAND+1  partial high word (signed when prod_is_signed)
//   mcand            in  BW_MCAND    captured multiplicand
//   mlier_bit        in  1           multiplier bit consumed this step
//   last_step        in  1           this is the final (MSB) multiplier bit
//   mcand_is_signed  in  1           mcand is two's complement
//   mlier_is_signed  in  1           mlier is two's complement
//   prod_is_signed   in  1           product is being formed in signed mode
//   sum_hi           out BW_MCAND+1  low bits of the step sum
//   carry            out 1           top bit of the step sum (sign in signed mode)

module mult_step #(
  parameter int BW_MCAND = 8
) (
  input  logic [BW_MCAND:0]   hi,
  input  logic [BW_MCAND-1:0] mcand,
  input  logic                mlier_bit,
  input  logic                last_step,
  input  logic                mcand_is_signed,
  input  logic                mlier_is_signed,
  input  logic                prod_is_signed,
  output logic [BW_MCAND:0]   sum_hi,
  output logic                carry
);

  // Two guard bits over the multiplicand: the partial word carries one extra
  // bit so an unsigned multiplicand still fits when the product is signed,
  // and the sum needs one more to stay exact.
  localparam int W = BW_MCAND + 2;

  logic [W-1:0] hi_ext;
  logic [W-1:0] mc_ext;
  logic [W-1:0] addend;
  logic         sub;
  logic [W-1:0] sum;

  always_comb begin
    hi_ext = {prod_is_signed & hi[BW_MCAND], hi};
    mc_ext = {{2{mcand_is_signed & mcand[BW_MCAND-1]}}, mcand};
    // The MSB of a two's-complement multiplier has negative weight.
    sub    = mlier_bit & last_step & mlier_is_signed;
    if (!mlier_bit) begin
      addend = '0;
    end else if (sub) begin
      addend = ~mc_ext;
    end else begin
      addend = mc_ext;
    end
    sum = hi_ext + addend + {{(W-1){1'b0}}, sub};
  end

  assign sum_hi = sum[BW_MCAND:0];
  assign carry  = sum[W-1];

endmodule

// File: rtl/mult_acc.sv
// rtl/mult_acc.sv - sequential shift-add multiply-accumulate unit
//
// Purpose: captures operands on start, forms the product one multiplier bit
//          per cycle (LSB first), then optionally loads or adds it into a wide
//          accumulator with a sticky overflow flag. done pulses for one cycle
//          when prod/acc/ovf are final.
// Ports:
//   clk              in  1                  clock, rising edge
//   rstx             in  1                  asynchronous active-low reset
//   start            in  1                  request, accepted only while idle
//   mcand_is_signed  in  1                  mcand is two's complement
//   mlier_is_signed  in  1                  mlier is two's complement
//   acc_en           in  1                  accumulate result into acc
//   acc_clr          in  1                  with acc_en: load instead of add
//   mcand            in  BW_MCAND           multiplicand
//   mlier            in  BW_MLIER           multiplier
//   prod             out BW_MCAND+BW_MLIER  product
//   acc              out BW_ACC             accumulator
//   ovf              out 1                  sticky accumulator overflow
//   busy             out 1                  operation in progress
//   done             out 1                  one-cycle completion pulse

module mult_acc
  import mult_pkg::*;
#(
  parameter int BW_MCAND = DEF_BW_MCAND,
  parameter int BW_MLIER = DEF_BW_MLIER,
  parameter int BW_ACC   = DEF_BW_ACC,
  parameter int BW_CNT   = cnt_width(BW_MLIER)
) (
  input  logic                         clk,
  input  logic                         rstx,
  input  logic                         start,
  input  logic                         mcand_is_signed,
  input  logic                         mlier_is_signed,
  input  logic                         acc_en,
  input  logic                         acc_clr,
  input  logic [BW_MCAND-1:0]          mcand,
  input  logic [BW_MLIER-1:0]          mlier,
  output logic [BW_MCAND+BW_MLIER-1:0] prod,
  output logic [BW_ACC-1:0]            acc,
  output logic                         ovf,
  output logic                         busy,
  output logic                         done
);

  localparam int BW_PROD = BW_MCAND + BW_MLIER;
  localparam int BW_HI   = BW_MCAND + 1;

  state_t                state_q;
  state_t                state_d;
  logic [BW_CNT-1:0]     cnt_q;
  logic [BW_MCAND-1:0]   mcand_q;
  logic                  mcand_s_q;
  logic                  mlier_s_q;
  logic                  acc_en_q;
  logic                  acc_clr_q;
  logic [BW_HI-1:0]      hi_q;
  logic [BW_MLIER-1:0]   lo_q;
  logic [BW_ACC-1:0]     acc_q;
  logic                  ovf_q;
  logic                  done_q;

  logic                  prod_signed;
  logic                  last_step;
  logic [BW_HI-1:0]      step_sum;
  logic                  step_carry;
  logic [BW_PROD-1:0]    prod_w;
  logic [BW_ACC-1:0]     prod_ext;
  logic [BW_ACC:0]       acc_sum;
  logic                  add_ovf;

  assign prod_signed = mcand_s_q | mlier_s_q;
  assign last_step   = (cnt_q == BW_CNT'(1));

  // The low word starts as the multiplier and fills with product bits from
  // the top as multiplier bits are consumed from the bottom, so after the
  // last step {hi, lo} is the full product.
  assign prod_w = {hi_q[BW_MCAND-1:0], lo_q};

  mult_step #(
    .BW_MCAND(BW_MCAND)
  ) u_step (
    .hi              (hi_q),
    .mcand           (mcand_q),
    .mlier_bit       (lo_q[0]),
    .last_step       (last_step),
    .mcand_is_signed (mcand_s_q),
    .mlier_is_signed (mlier_s_q),
    .prod_is_signed  (prod_signed),
    .sum_hi          (step_sum),
    .carry           (step_carry)
  );

  always_comb begin
    prod_ext                = {BW_ACC{prod_signed & prod_w[BW_PROD-1]}};
    prod_ext[BW_PROD-1:0]   = prod_w;
    acc_sum                 = {1'b0, acc_q} + {1'b0, prod_ext};
    if (prod_signed) begin
      add_ovf = (acc_q[BW_ACC-1] == prod_ext[BW_ACC-1]) &&
                (acc_sum[BW_ACC-1] != acc_q[BW_ACC-1]);
    end else begin
      add_ovf = acc_sum[BW_ACC];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MUL;
      MUL:     if (last_step) state_d = ACC;
      ACC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mcand_s_q <= 1'b0;
      mlier_s_q <= 1'b0;
      acc_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ACC);
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q   <= mcand;
            mcand_s_q <= mcand_is_signed;
            mlier_s_q <= mlier_is_signed;
            acc_en_q  <= acc_en;
            acc_clr_q <= acc_clr;
            hi_q      <= '0;
            lo_q      <= mlier;
            cnt_q     <= BW_CNT'(BW_MLIER);
          end
        end
        MUL: begin
          hi_q  <= {step_carry, step_sum[BW_HI-1:1]};
          lo_q  <= {step_sum[0], lo_q[BW_MLIER-1:1]};
          cnt_q <= cnt_q - 1'b1;
        end
        ACC: begin
          if (acc_en_q) begin
            if (acc_clr_q) begin
              acc_q <= prod_ext;
              ovf_q <= 1'b0;
            end else begin
              acc_q <= acc_sum[BW_ACC-1:0];
              ovf_q <= ovf_q | add_ovf;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign prod = prod_w;
  assign acc  = acc_q;
  assign ovf  = ovf_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mult_acc.sv
// tb/tb_mult_acc.sv - directed self-checking bench for mult_acc

module tb_mult_acc;

  logic        clk = 1'b0;
  logic        rstx;
  logic        start;
  logic        mcand_is_signed;
  logic        mlier_is_signed;
  logic        acc_en;
  logic        acc_clr;
  logic [7:0]  mcand;
  logic [7:0]  mlier;
  logic [15:0] prod;
  logic [19:0] acc;
  logic        ovf;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  mult_acc #(
    .BW_MCAND(8),
    .BW_MLIER(8),
    .BW_ACC  (20),
    .BW_CNT  (4)
  ) dut (
    .clk             (clk),
    .rstx            (rstx),
    .start           (start),
    .mcand_is_signed (mcand_is_signed),
    .mlier_is_signed (mlier_is_signed),
    .acc_en          (acc_en),
    .acc_clr         (acc_clr),
    .mcand           (mcand),
    .mlier           (mlier),
    .prod            (prod),
    .acc             (acc),
    .ovf             (ovf),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble the inputs right after acceptance, and wait
  // (bounded) for done. done must appear after the 9th edge following accept.
  task automatic run_op(input string tag, input logic ms, input logic ls,
                        input logic en, input logic clr,
                        input logic [7:0] a, input logic [7:0] b);
    int n;
    @(negedge clk);
    start = 1'b1;
    mcand_is_signed = ms;
    mlier_is_signed = ls;
    acc_en = en;
    acc_clr = clr;
    mcand = a;
    mlier = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    mcand = ~a;
    mlier = ~b;
    mcand_is_signed = ~ms;
    mlier_is_signed = ~ls;
    acc_en = ~en;
    acc_clr = ~clr;
    chk({tag, "_busy"}, busy, 1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, 9);
    chk({tag, "_idle_at_done"}, busy, 0);
  endtask

  initial begin
    rstx = 1'b0;
    start = 1'b0;
    mcand_is_signed = 1'b0;
    mlier_is_signed = 1'b0;
    acc_en = 1'b0;
    acc_clr = 1'b0;
    mcand = 8'h00;
    mlier = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prod", prod, 0);
    chk("rst_acc", acc, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rstx = 1'b1;

    // unsigned 255 x 255, load accumulator
    run_op("u255x255", 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
    chk("u255x255_prod", prod, 32'h0000_FE01);
    chk("u255x255_acc", acc, 32'h0000_FE01);
    chk("u255x255_ovf", ovf, 0);

    // signed -128 x -128, accumulator untouched
    run_op("s_m128sq", 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 8'h80);
    chk("s_m128sq_prod", prod, 32'h0000_4000);
    chk("s_m128sq_acc", acc, 32'h0000_FE01);

    // signed 127 x -128 = -16256
    run_op("s_127xm128", 1'b1, 1'b1, 1'b0, 1'b0, 8'h7F, 8'h80);
    chk("s_127xm128_prod", prod, 32'h0000_C080);

    // unsigned 0 x 0
    run_op("u0x0", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("u0x0_prod", prod, 0);

    // mixed: signed -1 x unsigned 255 = -255, sign-extended into acc
    run_op("mix", 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
    chk("mix_prod", prod, 32'h0000_FF01);
    chk("mix_acc", acc, 32'h000F_FF01);
    chk("mix_ovf", ovf, 0);

    // signed accumulate: load 16384, add 16384 thirty times -> 0x7C000
    run_op("ovf_load", 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 8'h80);
    chk("ovf_load_acc", acc, 32'h0000_4000);
    for (int k = 0; k < 30; k++) begin
      run_op($sformatf("ovf_add%0d", k), 1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 8'h80);
    end
    chk("ovf_edge_acc", acc, 32'h0007_C000);
    chk("ovf_edge_ovf", ovf, 0);
    // one more crosses 2^19-1
    run_op("ovf_cross", 1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 8'h80);
    chk("ovf_cross_acc", acc, 32'h0008_0000);
    chk("ovf_cross_ovf", ovf, 1);
    // mixed-sign add: no new overflow, flag stays sticky
    run_op("ovf_sticky", 1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 8'h80);
    chk("ovf_sticky_acc", acc, 32'h0008_4000);
    chk("ovf_sticky_ovf", ovf, 1);
    // acc_clr without acc_en does nothing
    run_op("clr_no_en", 1'b1, 1'b1, 1'b0, 1'b1, 8'h7F, 8'h7F);
    chk("clr_no_en_prod", prod, 32'h0000_3F01);
    chk("clr_no_en_acc", acc, 32'h0008_4000);
    chk("clr_no_en_ovf", ovf, 1);
    // clearing load resets ovf
    run_op("ovf_clear", 1'b1, 1'b1, 1'b1, 1'b1, 8'h7F, 8'h7F);
    chk("ovf_clear_acc", acc, 32'h0000_3F01);
    chk("ovf_clear_ovf", ovf, 0);

    // start held high with operands changing every cycle: only the ops at
    // edges 0, 10, 20 run; done after edges 9, 19, 29
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = 1'b1;
      mcand_is_signed = 1'b0;
      mlier_is_signed = 1'b0;
      acc_en = 1'b0;
      acc_clr = 1'b0;
      mcand = 8'(i + 1);
      mlier = 8'(i + 2);
      @(posedge clk);
      #1;
      chk($sformatf("b2b_done%0d", i), done, (i % 10 == 9) ? 1 : 0);
      if (i % 10 == 9) begin
        chk($sformatf("b2b_prod%0d", i), prod, (i - 8) * (i - 7));
      end
    end
    start = 1'b0;
    chk("b2b_acc", acc, 32'h0000_3F01);

    // reset mid-MUL
    @(negedge clk);
    start = 1'b1;
    mcand_is_signed = 1'b0;
    mlier_is_signed = 1'b0;
    acc_en = 1'b1;
    acc_clr = 1'b1;
    mcand = 8'd3;
    mlier = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    rstx = 1'b0;
    #1;
    chk("mid_rst_prod", prod, 0);
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rstx = 1'b1;
    run_op("post_rst", 1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 8'd5);
    chk("post_rst_prod", prod, 15);
    chk("post_rst_acc", acc, 15);
    @(posedge clk);
    #1;
    chk("post_rst_done_pulse", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
